bp_fe_bht_sched: RTL and testbench
==================================

Name: bp_fe_bht_sched

Overview:
Access scheduler for a single-ported, synchronous-read 2-bit-counter branch history table in the front end. It arbitrates between fetch-stage prediction reads and backend resolution updates; each update is a read-modify-write. After reset it initialises every entry to weakly-not-taken. Buffered updates and a starvation limit keep the two requester classes fair without stalling fetch in steady state.

Parameters:
bht_idx_width_p, 9, table index width; els = 2**bht_idx_width_p entries
upd_fifo_els_p, 4, update FIFO depth (power of 2, >=2)
starve_limit_p, 8, consecutive cycles with a pending update denied before the update takes priority (>=1)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset; asynchronous assert, active-low; one clock, reset is asynchronous and active-low
r_v_i  in  1  fetch prediction read request
r_idx_i  in  bht_idx_width_p  fetch read index
r_ready_o  out  1  read accepted this cycle when r_v_i & r_ready_o
predict_v_o  out  1  prediction valid; exactly 1 cycle after acceptance
predict_o  out  1  predicted taken (counter MSB)
w_v_i  in  1  resolved-branch update request
w_idx_i  in  bht_idx_width_p  update index
w_taken_i  in  1  actual outcome
w_ready_o  out  1  FIFO not full
init_done_o  out  1  initialisation sweep finished
mem_v_o  out  1  table access enable
mem_w_o  out  1  1 = write, 0 = read
mem_idx_o  out  bht_idx_width_p  table index
mem_data_o  out  2  write data
mem_data_i  in  2  read data, valid the cycle after a read

Behaviour:
- Reset (async, reset_n_i=0): state=INIT, sweep counter=0, FIFO empty, starve counter=0; all outputs 0 except mem_data_o=2'b01 while in INIT.
- INIT: each cycle mem_v_o=1, mem_w_o=1, mem_idx_o=sweep counter, mem_data_o=2'b01; counter increments. After writing index els-1, go to READY and set init_done_o=1 (held until reset). r_ready_o=0 during INIT. w_ready_o follows FIFO state; updates may be queued.
- READY, arbitration (one port access per cycle):
  - Update wins if FIFO non-empty AND (FIFO full OR starve counter == starve_limit_p OR r_v_i=0).
  - Otherwise a fetch read wins if r_v_i=1.
  - r_ready_o=1 only when the read wins; combinational on r_v_i, FIFO state and starve counter.
  - Fetch read: mem_v_o=1, mem_w_o=0, mem_idx_o=r_idx_i. Next cycle predict_v_o=1, predict_o=mem_data_i[1]. Stay in READY.
  - Update wins: issue read of the FIFO head index; go to UPD_WR; starve counter cleared.
- Starve counter: increments each READY cycle where FIFO is non-empty and the read wins; saturates at starve_limit_p.
- UPD_WR:
  - mem_v_o=1, mem_w_o=1, mem_idx_o=head index; FIFO pops this cycle; r_ready_o=0; return to READY.
  - mem_data_o is the saturating update of mem_data_i: taken -> +1 saturating at 2'b11; not taken -> -1 saturating at 2'b00.
- predict_v_o is 0 in every cycle not following an accepted read, including UPD_WR.
- FIFO: push when w_v_i & w_ready_o; push and pop may occur in the same cycle; no bypass. When full, w_ready_o=0 even if a pop occurs in that cycle.
- Hazard: a fetch read of an index with a queued, unapplied update returns the old counter. This is architecturally acceptable and needs no forwarding.
- Async reset mid-sweep or mid-RMW: abandon the operation, drop FIFO contents, restart INIT at index 0.

Test Plan:
- Reset release, bht_idx_width_p=4 -> 16 consecutive writes of 2'b01 to idx 0..15; init_done_o=1 in cycle 17; r_ready_o=0 throughout the sweep.
- After init, read idx 5 -> predict_v_o=1 next cycle with predict_o=0. Three taken updates to idx 5 -> written values 2'b10, 2'b11, 2'b11; a subsequent read gives predict_o=1.
- r_v_i held high continuously, one update pushed, starve_limit_p=8 -> update read issued on the 9th cycle after the push; fetch stalled for exactly 2 cycles.
- 4 pushes while r_v_i=1 fill the FIFO -> w_ready_o=0, update priority; 4 RMWs back-to-back in 8 cycles; w_ready_o returns to 1 the cycle after the first pop.
- Not-taken update on a counter at 2'b00 -> write of 2'b00. Simultaneous push and pop at occupancy 2 -> occupancy stays 2.
- Assert reset_n_i in UPD_WR -> mem_v_o=0 immediately, FIFO empty, INIT restarts at index 0 after release.

Source files
------------

// File: rtl/bp_fe_bht_sched.sv
// Access scheduler for a single-ported, synchronous-read 2-bit-counter BHT.
// Arbitrates fetch prediction reads against buffered read-modify-write updates.
module bp_fe_bht_sched #(
    parameter int bht_idx_width_p = 9,
    parameter int upd_fifo_els_p  = 4,
    parameter int starve_limit_p  = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       r_v_i,
    input  logic [bht_idx_width_p-1:0] r_idx_i,
    output logic                       r_ready_o,
    output logic                       predict_v_o,
    output logic                       predict_o,
    input  logic                       w_v_i,
    input  logic [bht_idx_width_p-1:0] w_idx_i,
    input  logic                       w_taken_i,
    output logic                       w_ready_o,
    output logic                       init_done_o,
    output logic                       mem_v_o,
    output logic                       mem_w_o,
    output logic [bht_idx_width_p-1:0] mem_idx_o,
    output logic [1:0]                 mem_data_o,
    input  logic [1:0]                 mem_data_i,
    output logic [1:0]                 state_o
);

    // Handshakes: a transfer happens in a cycle where valid & ready are both
    // high; valid never waits on ready, and ready may depend on valid.
    localparam int ptr_w    = $clog2(upd_fifo_els_p);
    localparam int starve_w = $clog2(starve_limit_p + 1);
    localparam logic [bht_idx_width_p-1:0] last_idx   = '1;
    localparam logic [starve_w-1:0]        starve_max = starve_w'(starve_limit_p);

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_READY  = 2'd1,
        S_UPD_WR = 2'd2
    } state_e;

    state_e                     state_r, state_n;
    logic [bht_idx_width_p-1:0] sweep_r;
    logic [starve_w-1:0]        starve_r;
    logic                       predict_v_r;

    logic [bht_idx_width_p:0]   fifo_mem [upd_fifo_els_p];
    logic [ptr_w:0]             wr_ptr_r, rd_ptr_r;
    logic                       fifo_empty, fifo_full, push, pop;
    logic [bht_idx_width_p:0]   head;
    logic [bht_idx_width_p-1:0] head_idx;
    logic                       head_taken;
    logic                       upd_win, rd_win;
    logic [1:0]                 upd_cnt;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_r == rd_ptr_r);
    assign fifo_full  = (wr_ptr_r[ptr_w] != rd_ptr_r[ptr_w]) &&
                        (wr_ptr_r[ptr_w-1:0] == rd_ptr_r[ptr_w-1:0]);
    assign w_ready_o  = reset_n_i & ~fifo_full;
    assign push       = w_v_i & w_ready_o;
    assign pop        = (state_r == S_UPD_WR);
    assign head       = fifo_mem[rd_ptr_r[ptr_w-1:0]];
    assign head_idx   = head[bht_idx_width_p-1:0];
    assign head_taken = head[bht_idx_width_p];

    assign upd_win = (state_r == S_READY) && !fifo_empty &&
                     (fifo_full || (starve_r == starve_max) || !r_v_i);
    assign rd_win  = (state_r == S_READY) && r_v_i && !upd_win;

    always_comb begin
        upd_cnt = mem_data_i;
        if (head_taken) begin
            if (mem_data_i != 2'b11) upd_cnt = mem_data_i + 2'b01;
        end else begin
            if (mem_data_i != 2'b00) upd_cnt = mem_data_i - 2'b01;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_r[ptr_w-1:0]] <= {w_taken_i, w_idx_i};
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= S_INIT;
            sweep_r     <= '0;
            starve_r    <= '0;
            predict_v_r <= 1'b0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
        end else begin
            state_r     <= state_n;
            predict_v_r <= rd_win;
            if (state_r == S_INIT) sweep_r <= sweep_r + 1'b1;
            if (push) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop) rd_ptr_r <= rd_ptr_r + 1'b1;
            if (upd_win) starve_r <= '0;
            else if (rd_win && !fifo_empty && starve_r != starve_max)
                starve_r <= starve_r + 1'b1;
        end
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            S_INIT:   if (sweep_r == last_idx) state_n = S_READY;
            S_READY:  if (upd_win) state_n = S_UPD_WR;
            S_UPD_WR: state_n = S_READY;
            default:  state_n = S_INIT;
        endcase
    end

    // The sweep is gated by reset_n_i so nothing is issued while reset is held.
    always_comb begin
        mem_v_o    = 1'b0;
        mem_w_o    = 1'b0;
        mem_idx_o  = '0;
        mem_data_o = 2'b00;
        r_ready_o  = 1'b0;
        case (state_r)
            S_INIT: begin
                mem_v_o    = reset_n_i;
                mem_w_o    = reset_n_i;
                mem_idx_o  = sweep_r;
                mem_data_o = 2'b01;
            end
            S_READY: begin
                r_ready_o = rd_win;
                if (upd_win) begin
                    mem_v_o   = 1'b1;
                    mem_idx_o = head_idx;
                end else if (rd_win) begin
                    mem_v_o   = 1'b1;
                    mem_idx_o = r_idx_i;
                end
            end
            S_UPD_WR: begin
                mem_v_o    = 1'b1;
                mem_w_o    = 1'b1;
                mem_idx_o  = head_idx;
                mem_data_o = upd_cnt;
            end
            default: ;
        endcase
    end

    assign predict_v_o = predict_v_r;
    assign predict_o   = predict_v_r & mem_data_i[1];
    assign init_done_o = (state_r != S_INIT);
    assign state_o     = state_r;

endmodule

// File: tb/tb_bp_fe_bht_sched.sv
// Bench for bp_fe_bht_sched: BHT memory model, prediction/write scoreboards,
// a per-cycle arbitration vector table and hand sequences for reset corners.
module tb_bp_fe_bht_sched;
  localparam int IW  = 4;
  localparam int ELS = 16;
  localparam int SL  = 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          r_v = 1'b0, w_v = 1'b0, w_taken = 1'b0;
  logic [IW-1:0] r_idx = '0, w_idx = '0;
  logic          r_ready_o, predict_v_o, predict_o, w_ready_o, init_done_o;
  logic          mem_v_o, mem_w_o;
  logic [IW-1:0] mem_idx_o;
  logic [1:0]    mem_data_o, mem_data_i, state_o;

  bp_fe_bht_sched #(
    .bht_idx_width_p(IW),
    .upd_fifo_els_p (4),
    .starve_limit_p (SL)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .r_v_i       (r_v),
    .r_idx_i     (r_idx),
    .r_ready_o   (r_ready_o),
    .predict_v_o (predict_v_o),
    .predict_o   (predict_o),
    .w_v_i       (w_v),
    .w_idx_i     (w_idx),
    .w_taken_i   (w_taken),
    .w_ready_o   (w_ready_o),
    .init_done_o (init_done_o),
    .mem_v_o     (mem_v_o),
    .mem_w_o     (mem_w_o),
    .mem_idx_o   (mem_idx_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .state_o     (state_o)
  );

  // synchronous-read table, starting from garbage so a missed sweep shows up
  logic [1:0] tbl [ELS];
  logic [1:0] rd_q = 2'b00;
  assign mem_data_i = rd_q;
  initial for (int i = 0; i < ELS; i++) tbl[i] = 2'b10;
  always @(posedge clk) begin
    if (mem_v_o) begin
      if (mem_w_o) tbl[mem_idx_o] <= mem_data_o;
      else rd_q <= tbl[mem_idx_o];
    end
  end

  // scoreboard state
  int total = 0;
  int bad = 0;
  logic [IW+1:0] exp_q[$];
  logic          pred_q[$];
  logic [1:0]    ref_cnt [ELS];
  logic [1:0]    pend_cnt [ELS];
  logic          pv_exp = 1'b0;
  bit            mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] sat_upd(input logic [1:0] c, input logic tk);
    if (tk) return (c == 2'b11) ? 2'b11 : c + 2'b01;
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  task automatic init_models();
    for (int i = 0; i < ELS; i++) begin
      ref_cnt[i]  = 2'b01;
      pend_cnt[i] = 2'b01;
    end
    exp_q.delete();
    pred_q.delete();
    pv_exp = 1'b0;
  endtask

  // monitor: accepted updates push expected writes, accepted reads push predictions
  always @(negedge clk) begin : mon
    logic [IW+1:0] e;
    logic          p;
    if (reset_n && mon_en) begin
      chk("predict_v", predict_v_o, pv_exp);
      if (predict_v_o && pv_exp) begin
        p = pred_q.pop_front();
        chk("predict", predict_o, p);
      end
      if (mem_v_o && mem_w_o) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: idx=%0d data=%0d, none required", mem_idx_o, mem_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("wr_idx", mem_idx_o, e[IW+1:2]);
          chk("wr_data", mem_data_o, e[1:0]);
          ref_cnt[e[IW+1:2]] = e[1:0];
        end
      end
      pv_exp = r_v && r_ready_o;
      if (pv_exp) pred_q.push_back(ref_cnt[r_idx][1]);
    end
    if (reset_n && w_v && w_ready_o) begin
      pend_cnt[w_idx] = sat_upd(pend_cnt[w_idx], w_taken);
      exp_q.push_back({w_idx, pend_cnt[w_idx]});
    end
  end

  // sweep after reset release: ELS writes of 01, then READY with init_done
  task automatic check_sweep();
    r_v = 1'b1;
    r_idx = 4'd3;
    for (int k = 0; k < ELS; k++) begin
      @(negedge clk);
      chk("sweep_v", mem_v_o, 1);
      chk("sweep_w", mem_w_o, 1);
      chk("sweep_idx", mem_idx_o, k);
      chk("sweep_data", mem_data_o, 2'b01);
      chk("sweep_r_ready", r_ready_o, 0);
      chk("sweep_done", init_done_o, 0);
    end
    r_v = 1'b0;
    @(negedge clk);
    chk("init_done", init_done_o, 1);
    chk("ready_state", state_o, 1);
    chk("ready_idle", mem_v_o, 0);
    mon_en = 1'b1;
  endtask

  typedef struct {
    logic          r_v;
    logic [IW-1:0] r_idx;
    logic          w_v;
    logic [IW-1:0] w_idx;
    logic          w_tk;
    logic          e_rr;
    logic          e_wr;
    logic          e_mv;
    logic          e_mw;
  } vec_t;

  vec_t tv [27];

  function automatic vec_t mk(input int rv, input int ri, input int wv, input int wi,
                              input int wt, input int rr, input int wr, input int mv, input int mw);
    vec_t v;
    v.r_v = rv[0]; v.r_idx = ri[IW-1:0]; v.w_v = wv[0]; v.w_idx = wi[IW-1:0];
    v.w_tk = wt[0]; v.e_rr = rr[0]; v.e_wr = wr[0]; v.e_mv = mv[0]; v.e_mw = mw[0];
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1);
  end

  initial begin
    // starvation: one update under a continuous read stream
    tv[0]  = mk(1, 3, 1, 7, 1,  1, 1, 1, 0);
    tv[1]  = mk(1, 5, 0, 0, 0,  1, 1, 1, 0);
    tv[2]  = mk(1, 6, 0, 0, 0,  1, 1, 1, 0);
    tv[3]  = mk(1, 5, 0, 0, 0,  1, 1, 1, 0);
    tv[4]  = mk(1, 1, 0, 0, 0,  1, 1, 1, 0);
    tv[5]  = mk(1, 2, 0, 0, 0,  1, 1, 1, 0);
    tv[6]  = mk(1, 5, 0, 0, 0,  1, 1, 1, 0);
    tv[7]  = mk(1, 8, 0, 0, 0,  1, 1, 1, 0);
    tv[8]  = mk(1, 9, 0, 0, 0,  1, 1, 1, 0);
    tv[9]  = mk(1, 4, 0, 0, 0,  0, 1, 1, 0);
    tv[10] = mk(1, 4, 0, 0, 0,  0, 1, 1, 1);
    tv[11] = mk(1, 7, 0, 0, 0,  1, 1, 1, 0);
    // fill the FIFO while reading, then drain back-to-back
    tv[12] = mk(1, 5, 1, 2, 0,  1, 1, 1, 0);
    tv[13] = mk(1, 0, 1, 2, 0,  1, 1, 1, 0);
    tv[14] = mk(1, 9, 1, 9, 1,  1, 1, 1, 0);
    tv[15] = mk(1, 5, 1, 9, 1,  1, 1, 1, 0);
    tv[16] = mk(1, 6, 1, 3, 1,  0, 0, 1, 0);
    tv[17] = mk(0, 0, 0, 0, 0,  0, 0, 1, 1);
    tv[18] = mk(0, 0, 0, 0, 0,  0, 1, 1, 0);
    tv[19] = mk(0, 0, 0, 0, 0,  0, 1, 1, 1);
    tv[20] = mk(0, 0, 0, 0, 0,  0, 1, 1, 0);
    tv[21] = mk(0, 0, 1, 11, 1, 0, 1, 1, 1);
    tv[22] = mk(0, 0, 0, 0, 0,  0, 1, 1, 0);
    tv[23] = mk(0, 0, 0, 0, 0,  0, 1, 1, 1);
    tv[24] = mk(0, 0, 0, 0, 0,  0, 1, 1, 0);
    tv[25] = mk(0, 0, 0, 0, 0,  0, 1, 1, 1);
    tv[26] = mk(0, 0, 0, 0, 0,  0, 1, 0, 0);

    // reset state
    init_models();
    r_v = 1'b1;
    w_v = 1'b1;
    w_idx = 4'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_r_ready", r_ready_o, 0);
    chk("rst_w_ready", w_ready_o, 0);
    chk("rst_predict_v", predict_v_o, 0);
    chk("rst_predict", predict_o, 0);
    chk("rst_init_done", init_done_o, 0);
    chk("rst_mem_v", mem_v_o, 0);
    chk("rst_mem_w", mem_w_o, 0);
    chk("rst_mem_idx", mem_idx_o, 0);
    chk("rst_mem_data", mem_data_o, 2'b01);
    w_v = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    check_sweep();

    // read idx 5, then three taken updates, then read again
    repeat (2) @(posedge clk);
    #1 r_v = 1'b1; r_idx = 4'd5;
    @(negedge clk);
    chk("rd5_ready", r_ready_o, 1);
    @(posedge clk);
    #1 r_v = 1'b0;
    @(negedge clk);
    chk("rd5_pv", predict_v_o, 1);
    chk("rd5_pred", predict_o, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 w_v = 1'b1; w_idx = 4'd5; w_taken = 1'b1;
    end
    @(posedge clk);
    #1 w_v = 1'b0;
    repeat (10) @(posedge clk);
    chk("drain5", exp_q.size(), 0);
    #1 r_v = 1'b1; r_idx = 4'd5;
    @(posedge clk);
    #1 r_v = 1'b0;
    @(negedge clk);
    chk("rd5_after_pv", predict_v_o, 1);
    chk("rd5_after", predict_o, 1);
    repeat (3) @(posedge clk);

    // per-cycle arbitration table
    for (int i = 0; i < 27; i++) begin
      @(posedge clk);
      #1;
      r_v = tv[i].r_v; r_idx = tv[i].r_idx;
      w_v = tv[i].w_v; w_idx = tv[i].w_idx; w_taken = tv[i].w_tk;
      @(negedge clk);
      chk($sformatf("row%0d_r_ready", i), r_ready_o, tv[i].e_rr);
      chk($sformatf("row%0d_w_ready", i), w_ready_o, tv[i].e_wr);
      chk($sformatf("row%0d_mem_v", i), mem_v_o, tv[i].e_mv);
      chk($sformatf("row%0d_mem_w", i), mem_w_o, tv[i].e_mw);
    end
    @(posedge clk);
    #1 r_v = 1'b0; w_v = 1'b0;
    repeat (4) @(posedge clk);
    chk("table_drain", exp_q.size(), 0);

    // reset asserted during UPD_WR with a second entry still queued
    #1 w_v = 1'b1; w_idx = 4'd12; w_taken = 1'b1;
    @(posedge clk);
    #1 w_idx = 4'd13;
    @(negedge clk);
    chk("pre_rmw_read", mem_v_o && !mem_w_o, 1);
    @(posedge clk);
    #1 w_v = 1'b0;
    chk("rmw_state", state_o, 2);
    chk("rmw_write", mem_w_o, 1);
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rmw_rst_mem_v", mem_v_o, 0);
    chk("rmw_rst_mem_w", mem_w_o, 0);
    chk("rmw_rst_init_done", init_done_o, 0);
    chk("rmw_rst_state", state_o, 0);
    init_models();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check_sweep();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_fifo_empty", mem_v_o, 0);
      chk("post_rst_w_ready", w_ready_o, 1);
    end
    chk("final_wr_q", exp_q.size(), 0);
    chk("final_pred_q", pred_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
